// File: rtl/uart_info_scheduler_pkg.sv
// ============================================================================
// Module      : uart_info_scheduler_pkg
// Description : UART register-port types, offsets and scheduler FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_info_scheduler_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_ADDR_WIDTH = 4;
  localparam int UART_INFO_WIDTH = 64;

  typedef logic [UART_DATA_WIDTH-1:0] uart_t;
  typedef logic [UART_ADDR_WIDTH-1:0] addr_t;
  typedef logic [UART_INFO_WIDTH-1:0] UartInfo;

  localparam addr_t DATA_REG_OFFSET  = addr_t'(0);
  localparam addr_t STATE_REG_OFFSET = addr_t'(1);

  localparam int UART_INFO_BYTES   = UART_INFO_WIDTH / UART_DATA_WIDTH;
  localparam int TX_READY_BIT_DFLT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2
  } uart_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_info_scheduler_if.sv
// ============================================================================
// Module      : uart_info_scheduler_if
// Description : Single-master register bus toward the UART MMIO slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_info_scheduler_if
  import uart_info_scheduler_pkg::*;
();

  logic  uart_req;
  logic  uart_we;
  addr_t uart_addr;
  uart_t uart_wdata;
  logic  uart_ack;
  uart_t uart_rdata;

  modport master (
    output uart_req,
    output uart_we,
    output uart_addr,
    output uart_wdata,
    input  uart_ack,
    input  uart_rdata
  );

  modport slave (
    input  uart_req,
    input  uart_we,
    input  uart_addr,
    input  uart_wdata,
    output uart_ack,
    output uart_rdata
  );

endinterface

`default_nettype wire

// File: rtl/uart_info_scheduler_rr_arbiter.sv
// ============================================================================
// Module      : uart_rr_arbiter
// Description : Combinational round-robin pick: first request at/after ptr_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = IDW + 1;

  logic [CW-1:0] cand;
  logic          found;

  // ptr_i + i < 2*NREQ always fits in CW bits, so one subtract wraps it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NREQ; i++) begin
        cand = {1'b0, ptr_i} + CW'(i);
        if (cand >= CW'(NREQ)) begin
          cand = cand - CW'(NREQ);
        end
        if (!found && req_i[cand[IDW-1:0]]) begin
          found                 = 1'b1;
          gnt_o[cand[IDW-1:0]]  = 1'b1;
          idx_o                 = cand[IDW-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_info_scheduler.sv
// ============================================================================
// Module      : uart_info_scheduler
// Description : Arbitrates 64-bit info words and streams them LSB-first to UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_info_scheduler
  import uart_info_scheduler_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int TX_READY_BIT = TX_READY_BIT_DFLT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  input  UartInfo [NREQ-1:0]         req_info_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic                       done_o,
  output logic [$clog2(NREQ)-1:0]    done_id_o,
  output logic                       busy_o,
  uart_info_scheduler_if.master      uart
);

  localparam int IDW = $clog2(NREQ);

  uart_sched_state_t state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [2:0]        cnt_q, cnt_d;
  UartInfo           shift_q, shift_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              arb_en;

  assign arb_en = (state_q == IDLE);

  uart_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Bus outputs depend only on registered state, so they hold until uart_ack.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    shift_d         = shift_q;
    req_ready_o     = '0;
    done_o          = 1'b0;
    uart.uart_req   = 1'b0;
    uart.uart_we    = 1'b0;
    uart.uart_addr  = '0;
    uart.uart_wdata = '0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          req_ready_o = gnt;
          shift_d     = req_info_i[gnt_idx];
          id_d        = gnt_idx;
          cnt_d       = '0;
          ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d     = POLL;
        end
      end
      POLL: begin
        uart.uart_req  = 1'b1;
        uart.uart_addr = STATE_REG_OFFSET;
        if (uart.uart_ack && uart.uart_rdata[TX_READY_BIT]) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        uart.uart_req   = 1'b1;
        uart.uart_we    = 1'b1;
        uart.uart_addr  = DATA_REG_OFFSET;
        uart.uart_wdata = shift_q[UART_DATA_WIDTH-1:0];
        if (uart.uart_ack) begin
          shift_d = shift_q >> UART_DATA_WIDTH;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'(UART_INFO_BYTES - 1)) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = POLL;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done_id_o = id_q;
  assign busy_o    = (state_q != IDLE);

endmodule

`default_nettype wire
